// File: rtl/controlador_copia.sv
// controlador_copia: memory-to-memory copy engine that sits between the
// processor and the data memory. While idle it is transparent to the
// processor; once started it owns the memory port and moves tamanho bytes
// from origem to destino, one read cycle and one write cycle per byte.
module controlador_copia #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inicio,
    input  logic [LARGURA-1:0] origem,
    input  logic [LARGURA-1:0] destino,
    input  logic [LARGURA-1:0] tamanho,
    output logic               ocupado,
    output logic               concluido,
    input  logic               cpu_writeEnable,
    input  logic [LARGURA-1:0] cpu_endereco,
    input  logic [LARGURA-1:0] cpu_dadoEntrada,
    output logic [LARGURA-1:0] cpu_dadoSaida,
    output logic               mem_writeEnable,
    output logic [LARGURA-1:0] mem_endereco,
    output logic [LARGURA-1:0] mem_dadoEntrada,
    input  logic [LARGURA-1:0] mem_dadoSaida
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] LER      = 2'd1;
    localparam logic [1:0] ESCREVER = 2'd2;
    localparam logic [1:0] FIM      = 2'd3;

    logic [1:0]         estado;
    logic [LARGURA-1:0] origem_reg;
    logic [LARGURA-1:0] destino_reg;
    logic [LARGURA-1:0] tamanho_reg;
    logic [LARGURA-1:0] i;
    logic [LARGURA-1:0] buffer;
    logic [LARGURA:0]   proximo;

    // One extra bit so the "more bytes left" test cannot wrap when tamanho=255.
    assign proximo = {1'b0, i} + {{LARGURA{1'b0}}, 1'b1};

    // Sequencing: latch operands on start, then alternate read/write per byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= OCIOSO;
            origem_reg  <= '0;
            destino_reg <= '0;
            tamanho_reg <= '0;
            i           <= '0;
            buffer      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        origem_reg  <= origem;
                        destino_reg <= destino;
                        tamanho_reg <= tamanho;
                        i           <= '0;
                        estado      <= (tamanho != '0) ? LER : FIM;
                    end
                end
                LER: begin
                    buffer <= mem_dadoSaida;
                    estado <= ESCREVER;
                end
                ESCREVER: begin
                    i      <= proximo[LARGURA-1:0];
                    estado <= (proximo < {1'b0, tamanho_reg}) ? LER : FIM;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // Memory port mux: processor owns it when idle, the engine otherwise.
    always_comb begin
        mem_writeEnable = 1'b0;
        mem_endereco    = cpu_endereco;
        mem_dadoEntrada = cpu_dadoEntrada;
        case (estado)
            OCIOSO: begin
                mem_writeEnable = cpu_writeEnable;
            end
            LER: begin
                mem_endereco = origem_reg + i;
            end
            ESCREVER: begin
                mem_endereco    = destino_reg + i;
                mem_dadoEntrada = buffer;
                // A reset landing on a write cycle aborts that byte too, so a
                // mid-copy reset leaves only the bytes completed before it.
                mem_writeEnable = ~rst;
            end
            default: begin
                mem_writeEnable = 1'b0;
            end
        endcase
    end

    assign cpu_dadoSaida = mem_dadoSaida;
    assign ocupado       = (estado == LER) || (estado == ESCREVER);
    assign concluido     = (estado == FIM);

endmodule

// File: tb/tb_controlador_copia.sv
// Bench for controlador_copia: behavioural data memory, reference memory
// image, and a write scoreboard holding every store the memory should see.
module tb_controlador_copia;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio;
    logic [7:0] origem, destino, tamanho;
    logic       ocupado, concluido;
    logic       cpu_writeEnable;
    logic [7:0] cpu_endereco, cpu_dadoEntrada, cpu_dadoSaida;
    logic       mem_writeEnable;
    logic [7:0] mem_endereco, mem_dadoEntrada, mem_dadoSaida;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    wr_t        exp_q[$];
    int         errs = 0;
    int         checks = 0;
    int         conc_cnt = 0;

    controlador_copia #(.LARGURA(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .inicio          (inicio),
        .origem          (origem),
        .destino         (destino),
        .tamanho         (tamanho),
        .ocupado         (ocupado),
        .concluido       (concluido),
        .cpu_writeEnable (cpu_writeEnable),
        .cpu_endereco    (cpu_endereco),
        .cpu_dadoEntrada (cpu_dadoEntrada),
        .cpu_dadoSaida   (cpu_dadoSaida),
        .mem_writeEnable (mem_writeEnable),
        .mem_endereco    (mem_endereco),
        .mem_dadoEntrada (mem_dadoEntrada),
        .mem_dadoSaida   (mem_dadoSaida)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge.
    assign mem_dadoSaida = mem[mem_endereco];
    always @(posedge clk) begin
        if (mem_writeEnable) mem[mem_endereco] <= mem_dadoEntrada;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every store the memory sees must be the next one on the scoreboard.
    always @(negedge clk) begin
        if (concluido) conc_cnt++;
        if (mem_writeEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexp_wr", {16'd0, mem_endereco, mem_dadoEntrada}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, mem_endereco}, {24'd0, e.a});
                chk("wr_data", {24'd0, mem_dadoEntrada}, {24'd0, e.d});
            end
        end
    end

    // Launch a copy, push its expected stores, and measure busy/done timing.
    task automatic run_copy(input logic [7:0] o, input logic [7:0] d,
                            input logic [7:0] t, input logic cpu_poke);
        int n, occ, first;
        @(posedge clk); #1;
        origem = o; destino = d; tamanho = t; inicio = 1'b1;
        for (int k = 0; k < int'(t); k++) begin
            logic [7:0] sa, da;
            sa = o + 8'(k);
            da = d + 8'(k);
            ref_mem[da] = ref_mem[sa];
            exp_q.push_back('{a: da, d: ref_mem[sa]});
        end
        @(posedge clk); #1;
        inicio = 1'b0;
        origem = ~o; destino = ~d; tamanho = 8'd1;
        if (cpu_poke) begin
            cpu_writeEnable = 1'b1; cpu_endereco = 8'd40; cpu_dadoEntrada = 8'h99;
        end
        n = 0; occ = 0; first = 0;
        while (first == 0 && n < 2 * int'(t) + 20) begin
            @(negedge clk);
            n++;
            if (ocupado) occ++;
            if (concluido) begin
                first = n;
                cpu_writeEnable = 1'b0;
            end
        end
        cpu_writeEnable = 1'b0;
        chk("conc_cycle", first, 2 * int'(t) + 1);
        chk("busy_cycles", occ, 2 * int'(t));
        @(negedge clk);
        chk("idle_after", {30'd0, ocupado, concluido}, 32'd0);
        for (int k = 0; k < int'(t); k++) begin
            logic [7:0] da;
            da = d + 8'(k);
            chk("dst_byte", {24'd0, mem[da]}, {24'd0, ref_mem[da]});
        end
    endtask

    initial begin
        int c0;
        rst = 1'b1; inicio = 1'b0; origem = '0; destino = '0; tamanho = '0;
        cpu_writeEnable = 1'b0; cpu_endereco = 8'd5; cpu_dadoEntrada = '0;
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'($urandom_range(0, 255));
        end
        mem[10] = 8'd11; mem[11] = 8'd22; mem[12] = 8'd33; mem[13] = 8'd44;
        mem[20] = 8'd7;
        for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, ocupado}, 32'd0);
        chk("rst_done", {31'd0, concluido}, 32'd0);
        chk("rst_we", {31'd0, mem_writeEnable}, 32'd0);
        chk("pass_addr", {24'd0, mem_endereco}, 32'd5);
        chk("pass_load", {24'd0, cpu_dadoSaida}, {24'd0, ref_mem[5]});

        // Basic copy with a processor store attempted throughout.
        run_copy(8'd10, 8'd40, 8'd4, 1'b1);
        chk("copy_40", {24'd0, mem[40]}, 32'd11);
        chk("copy_43", {24'd0, mem[43]}, 32'd44);

        // The same store while idle goes straight through.
        @(posedge clk); #1;
        cpu_writeEnable = 1'b1; cpu_endereco = 8'd40; cpu_dadoEntrada = 8'h99;
        exp_q.push_back('{a: 8'd40, d: 8'h99});
        ref_mem[40] = 8'h99;
        @(posedge clk); #1;
        cpu_writeEnable = 1'b0;
        @(negedge clk);
        chk("cpu_store", {24'd0, mem[40]}, 32'h99);

        // No-op, wrap-around and overlapping copies.
        run_copy(8'd60, 8'd70, 8'd0, 1'b0);
        run_copy(8'hFE, 8'h80, 8'd4, 1'b0);
        run_copy(8'd20, 8'd21, 8'd3, 1'b0);
        chk("overlap_23", {24'd0, mem[23]}, 32'd7);

        // Reset in the third write cycle of a 6-byte copy.
        c0 = conc_cnt;
        @(posedge clk); #1;
        origem = 8'd100; destino = 8'd150; tamanho = 8'd6; inicio = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ref_mem[150 + k] = ref_mem[100 + k];
            exp_q.push_back('{a: 8'(150 + k), d: ref_mem[100 + k]});
        end
        @(posedge clk); #1 inicio = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", {31'd0, mem_writeEnable}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, ocupado}, 32'd0);
        chk("rst_mid_done", {31'd0, concluido}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_conc", conc_cnt, c0);
        chk("rst_byte2", {24'd0, mem[152]}, {24'd0, ref_mem[152]});
        chk("rst_byte1", {24'd0, mem[151]}, {24'd0, ref_mem[101]});

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        rst = 1'b1; inicio = 1'b1; tamanho = 8'd3;
        @(posedge clk); #1;
        rst = 1'b0; inicio = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", {31'd0, ocupado}, 32'd0);
        chk("rst_prio_done", {31'd0, concluido}, 32'd0);

        chk("q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/controlador_copia.md
CONTROLADOR_COPIA -- requirements
Module: controlador_copia

Interface
REQ-001 SHALL have parameter: LARGURA, 8, data and address width in bits; the only supported value is 8, matching the data memory.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: inicio  input  1  start request, sampled only in OCIOSO.
REQ-005 SHALL have port: origem  input  8  source base address.
REQ-006 SHALL have port: destino  input  8  destination base address.
REQ-007 SHALL have port: tamanho  input  8  byte count; 0 = no-op.
REQ-008 SHALL have port: ocupado  output  1  copy in progress.
REQ-009 SHALL have port: concluido  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: cpu_writeEnable  input  1  processor store strobe.
REQ-011 SHALL have port: cpu_endereco  input  8  processor address.
REQ-012 SHALL have port: cpu_dadoEntrada  input  8  processor store data.
REQ-013 SHALL have port: cpu_dadoSaida  output  8  processor load data, always equal to mem_dadoSaida.
REQ-014 SHALL have port: mem_writeEnable  output  1  to data memory writeEnable.
REQ-015 SHALL have port: mem_endereco  output  8  to data memory endereco.
REQ-016 SHALL have port: mem_dadoEntrada  output  8  to data memory dadoEntrada.
REQ-017 SHALL have port: mem_dadoSaida  input  8  from data memory dadoSaida (combinational read).

Function
REQ-018 SHALL implement FSM states OCIOSO, LER, ESCREVER, FIM.
REQ-019 SHALL, in OCIOSO, pass cpu_writeEnable, cpu_endereco and cpu_dadoEntrada through combinationally to mem_writeEnable, mem_endereco and mem_dadoEntrada.
REQ-020 SHALL, in OCIOSO with inicio=1, latch origem, destino and tamanho into internal registers and clear byte index i to 0.
REQ-021 SHALL, after the start of REQ-020, go to LER if tamanho != 0, else go to FIM.
REQ-022 SHALL, in LER, drive mem_endereco = origem_reg + i (mod 256) and mem_writeEnable=0, capture mem_dadoSaida into buffer, and go to ESCREVER.
REQ-023 SHALL, in ESCREVER, drive mem_endereco = destino_reg + i (mod 256), mem_dadoEntrada = buffer and mem_writeEnable=1.
REQ-024 SHALL, in ESCREVER, increment i and go to LER if i+1 < tamanho_reg, else go to FIM.
REQ-025 SHALL, in FIM, assert concluido=1 for exactly one cycle with mem_writeEnable=0, then go to OCIOSO.
REQ-026 SHALL assert ocupado=1 exactly in LER and ESCREVER, and 0 otherwise.
REQ-027 SHALL, in any state other than OCIOSO, block processor stores (cpu_writeEnable has no effect) and ignore inicio.
REQ-028 SHALL take exactly 2*tamanho cycles of ocupado per copy, with concluido high in cycle 2*tamanho+1 after the sampling edge (cycle 1 when tamanho=0).
REQ-029 SHALL wrap both address sums modulo 256; e.g. origem=8'hFE, tamanho=4 reads FE, FF, 00, 01.
REQ-030 SHALL perform overlapping regions strictly as ascending byte-by-byte read-then-write; destino = origem+1 therefore replicates byte origem across the region.
REQ-031 SHALL treat tamanho=8'hFF as 255 bytes; the index register is 8 bits.
REQ-032 SHALL make later changes to origem, destino and tamanho while busy have no effect on the copy in progress.

Reset
REQ-033 SHALL, on rst=1 at a rising edge, enter OCIOSO with ocupado=0, concluido=0, i=0, buffer=0 and all latched operand registers 0.
REQ-034 SHALL let rst take priority over inicio in the same cycle.
REQ-035 SHALL, on reset mid-copy, abort without a concluido pulse; bytes already written remain in memory.

Verification
REQ-036 SHALL verify copy: mem[10..13]=11,22,33,44, inicio with origem=10, destino=40, tamanho=4 -> mem[40..43]=11,22,33,44; ocupado high 8 cycles; concluido pulse in cycle 9.
REQ-037 SHALL verify no-op: tamanho=0 -> ocupado never high, concluido in cycle 1, no memory write.
REQ-038 SHALL verify wrap: origem=8'hFE, destino=8'h80, tamanho=4 -> mem[80..83] = mem[FE], mem[FF], mem[00], mem[01].
REQ-039 SHALL verify blocking: cpu_writeEnable=1 to address 40 during the copy -> no effect; the same store in OCIOSO writes mem[40].
REQ-040 SHALL verify reset mid-copy: rst asserted in the third ESCREVER of a 6-byte copy -> next cycle OCIOSO, ocupado=0; only 2 destination bytes written; no concluido.
REQ-041 SHALL verify overlap: mem[20]=7, origem=20, destino=21, tamanho=3 -> mem[21..23]=7,7,7.
